// File: rtl/mem_arb_nch_if.sv
// Bundle of per-channel request/response buses and the downstream memory port.
interface mem_arb_nch_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned MASK_W = DATA_W / 8;

  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*MASK_W-1:0] ch_rmask;
  logic [NUM_CH*MASK_W-1:0] ch_wmask;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [NUM_CH*DATA_W-1:0] ch_rdata;
  logic [NUM_CH-1:0]        ch_resp;
  logic [ADDR_W-1:0]        mem_addr;
  logic [MASK_W-1:0]        mem_rmask;
  logic [MASK_W-1:0]        mem_wmask;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata;
  logic                     mem_resp;

  // Arbiter side.
  modport slave (
    input  ch_addr, ch_rmask, ch_wmask, ch_wdata, mem_rdata, mem_resp,
    output ch_rdata, ch_resp, mem_addr, mem_rmask, mem_wmask, mem_wdata
  );

  // Client and memory-model side.
  modport master (
    output ch_addr, ch_rmask, ch_wmask, ch_wdata, mem_rdata, mem_resp,
    input  ch_rdata, ch_resp, mem_addr, mem_rmask, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/mem_arb_nch.sv
// N-channel round-robin arbiter onto a single mask/resp memory port, with one-entry
// request buffers per channel and a sticky first-error monitor.
module mem_arb_nch #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_arb_nch_if.slave           bus,
  output logic                   error,
  output logic [$clog2(NUM_CH):0] error_ch
);
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CH_W   = $clog2(NUM_CH);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;
  state_e state_q, state_d;

  logic [NUM_CH-1:0]             pend_q, pend_d;
  logic [NUM_CH-1:0][ADDR_W-1:0] paddr_q, paddr_d;
  logic [NUM_CH-1:0][MASK_W-1:0] prmask_q, prmask_d;
  logic [NUM_CH-1:0][MASK_W-1:0] pwmask_q, pwmask_d;
  logic [NUM_CH-1:0][DATA_W-1:0] pwdata_q, pwdata_d;

  logic [CH_W-1:0] rr_q, rr_d, owner_q, owner_d, gnt_idx;
  logic            gnt_found;

  logic [ADDR_W-1:0]             mem_addr_q, mem_addr_d;
  logic [MASK_W-1:0]             mem_rmask_q, mem_rmask_d, mem_wmask_q, mem_wmask_d;
  logic [DATA_W-1:0]             mem_wdata_q, mem_wdata_d;
  logic [NUM_CH-1:0][DATA_W-1:0] ch_rdata_q, ch_rdata_d;
  logic [NUM_CH-1:0]             ch_resp_q, ch_resp_d;
  logic                          error_q, error_d;
  logic [CH_W:0]                 error_ch_q, error_ch_d;

  logic [NUM_CH-1:0] req_rd, req_wr, ch_free, req_err;
  logic              mem_err;

  // Decode request pulses; the owner is free again during its RESP cycle.
  always_comb begin
    req_rd  = '0;
    req_wr  = '0;
    ch_free = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_rd[i]  = |bus.ch_rmask[i*MASK_W +: MASK_W];
      req_wr[i]  = |bus.ch_wmask[i*MASK_W +: MASK_W];
      ch_free[i] = !pend_q[i] || (state_q == StResp && owner_q == CH_W'(i));
    end
  end

  // Capture legal requests into the per-channel buffers; capture beats the RESP clear.
  always_comb begin
    pend_d   = pend_q;
    paddr_d  = paddr_q;
    prmask_d = prmask_q;
    pwmask_d = pwmask_q;
    pwdata_d = pwdata_q;
    req_err  = '0;
    if (state_q == StResp) pend_d[owner_q] = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (req_rd[i] && req_wr[i]) begin
        req_err[i] = 1'b1;
      end else if ((req_rd[i] || req_wr[i]) && !ch_free[i]) begin
        req_err[i] = 1'b1;
      end else if (req_rd[i] || req_wr[i]) begin
        pend_d[i]   = 1'b1;
        paddr_d[i]  = bus.ch_addr[i*ADDR_W +: ADDR_W];
        prmask_d[i] = bus.ch_rmask[i*MASK_W +: MASK_W];
        pwmask_d[i] = bus.ch_wmask[i*MASK_W +: MASK_W];
        pwdata_d[i] = bus.ch_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin pick: first pending channel at or after rr.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (pend_q[idx] && !gnt_found) begin
        gnt_found = 1'b1;
        gnt_idx   = CH_W'(idx);
      end
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_found) state_d = StIssue;
      StIssue: state_d = bus.mem_resp ? StResp : StWait;
      StWait:  if (bus.mem_resp) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: downstream request registers, owner/rr, and channel responses.
  always_comb begin
    owner_d     = owner_q;
    rr_d        = rr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rmask_d = '0;
    mem_wmask_d = '0;
    ch_rdata_d  = ch_rdata_q;
    ch_resp_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          owner_d     = gnt_idx;
          rr_d        = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
          mem_addr_d  = paddr_q[gnt_idx];
          mem_rmask_d = prmask_q[gnt_idx];
          mem_wmask_d = pwmask_q[gnt_idx];
          mem_wdata_d = pwdata_q[gnt_idx];
        end
      end
      StIssue, StWait: begin
        if (bus.mem_resp) begin
          ch_rdata_d[owner_q] = bus.mem_rdata;
          ch_resp_d[owner_q]  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sticky first-error capture; channels outrank the downstream port, low index first.
  always_comb begin
    mem_err    = bus.mem_resp && (state_q == StIdle || state_q == StResp);
    error_d    = error_q;
    error_ch_d = error_ch_q;
    if (!error_q) begin
      if (|req_err) begin
        error_d = 1'b1;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
          if (req_err[i]) error_ch_d = (CH_W+1)'(i);
        end
      end else if (mem_err) begin
        error_d    = 1'b1;
        error_ch_d = (CH_W+1)'(NUM_CH);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      paddr_q     <= '0;
      prmask_q    <= '0;
      pwmask_q    <= '0;
      pwdata_q    <= '0;
      rr_q        <= '0;
      owner_q     <= '0;
      mem_addr_q  <= '0;
      mem_rmask_q <= '0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
      ch_rdata_q  <= '0;
      ch_resp_q   <= '0;
      error_q     <= 1'b0;
      error_ch_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      paddr_q     <= paddr_d;
      prmask_q    <= prmask_d;
      pwmask_q    <= pwmask_d;
      pwdata_q    <= pwdata_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      mem_addr_q  <= mem_addr_d;
      mem_rmask_q <= mem_rmask_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
      ch_rdata_q  <= ch_rdata_d;
      ch_resp_q   <= ch_resp_d;
      error_q     <= error_d;
      error_ch_q  <= error_ch_d;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_rmask = mem_rmask_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.ch_rdata  = ch_rdata_q;
  assign bus.ch_resp   = ch_resp_q;
  assign error         = error_q;
  assign error_ch      = error_ch_q;
endmodule

// File: tb/tb_mem_arb_nch.sv
// Directed bench for mem_arb_nch with NUM_CH=2, 32-bit address and data.
module tb_mem_arb_nch;
  logic       clk = 1'b0;
  logic       rst;
  logic       error;
  logic [1:0] error_ch;
  int         n_checks = 0;
  int         n_pass   = 0;

  mem_arb_nch_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) bus ();

  mem_arb_nch #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .error    (error),
    .error_ch (error_ch)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven and outputs read here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ch_addr   = '0;
    bus.ch_rmask  = '0;
    bus.ch_wmask  = '0;
    bus.ch_wdata  = '0;
    bus.mem_rdata = '0;
    bus.mem_resp  = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.mem_rmask !== 4'h0) $display("FAIL reset_rmask got %h want 0", bus.mem_rmask);
    else n_pass++;
    n_checks++;
    if (bus.mem_wmask !== 4'h0) $display("FAIL reset_wmask got %h want 0", bus.mem_wmask);
    else n_pass++;
    n_checks++;
    if (bus.mem_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", bus.mem_addr);
    else n_pass++;
    n_checks++;
    if (bus.mem_wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", bus.mem_wdata);
    else n_pass++;
    n_checks++;
    if (bus.ch_resp !== 2'b00) $display("FAIL reset_resp got %b want 00", bus.ch_resp);
    else n_pass++;
    n_checks++;
    if (bus.ch_rdata !== 64'h0) $display("FAIL reset_rdata got %h want 0", bus.ch_rdata);
    else n_pass++;
    n_checks++;
    if (error !== 1'b0 || error_ch !== 2'd0)
      $display("FAIL reset_error got %b/%0d want 0/0", error, error_ch);
    else n_pass++;
  endtask

  task automatic test_single_read();
    do_reset();
    bus.ch_addr[31:0] = 32'h100;
    bus.ch_rmask[3:0] = 4'hF;
    tick();
    clear_inputs();
    n_checks++;
    if (bus.mem_rmask !== 4'h0) $display("FAIL read_early_rmask got %h want 0", bus.mem_rmask);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.mem_rmask !== 4'hF || bus.mem_addr !== 32'h100)
      $display("FAIL read_issue got %h@%h want f@100", bus.mem_rmask, bus.mem_addr);
    else n_pass++;
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    tick();
    clear_inputs();
    n_checks++;
    if (bus.ch_resp !== 2'b01 || bus.ch_rdata[31:0] !== 32'hDEADBEEF)
      $display("FAIL read_resp got %b/%h want 01/deadbeef", bus.ch_resp, bus.ch_rdata[31:0]);
    else n_pass++;
    n_checks++;
    if (bus.mem_rmask !== 4'h0) $display("FAIL read_rmask_drop got %h want 0", bus.mem_rmask);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.ch_resp !== 2'b00) $display("FAIL read_resp_pulse got %b want 00", bus.ch_resp);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.ch_addr       = {32'h300, 32'h200};
    bus.ch_rmask[3:0] = 4'hF;
    bus.ch_wmask[7:4] = 4'hC;
    bus.ch_wdata      = {32'h12345678, 32'h0};
    tick();
    clear_inputs();
    tick();
    n_checks++;
    if (bus.mem_addr !== 32'h200 || bus.mem_rmask !== 4'hF)
      $display("FAIL rr_first got %h@%h want f@200", bus.mem_rmask, bus.mem_addr);
    else n_pass++;
    n_checks++;
    if (dut.rr_q !== 1'b1) $display("FAIL rr_after_ch0 got %0d want 1", dut.rr_q);
    else n_pass++;
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'hA5A5A5A5;
    tick();
    clear_inputs();
    n_checks++;
    if (bus.ch_resp !== 2'b01) $display("FAIL rr_resp0 got %b want 01", bus.ch_resp);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (bus.mem_addr !== 32'h300 || bus.mem_wmask !== 4'hC || bus.mem_rmask !== 4'h0 ||
        bus.mem_wdata !== 32'h12345678)
      $display("FAIL rr_second got a=%h w=%h r=%h d=%h want a=300 w=c r=0 d=12345678",
               bus.mem_addr, bus.mem_wmask, bus.mem_rmask, bus.mem_wdata);
    else n_pass++;
    n_checks++;
    if (dut.rr_q !== 1'b0) $display("FAIL rr_after_ch1 got %0d want 0", dut.rr_q);
    else n_pass++;
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h0BADF00D;
    tick();
    clear_inputs();
    n_checks++;
    if (bus.ch_resp !== 2'b10) $display("FAIL rr_resp1 got %b want 10", bus.ch_resp);
    else n_pass++;
    n_checks++;
    if (bus.ch_rdata[31:0] !== 32'hA5A5A5A5)
      $display("FAIL rr_nonowner_hold got %h want a5a5a5a5", bus.ch_rdata[31:0]);
    else n_pass++;
    tick();
    // Second simultaneous pair: rr=0 so ch0 wins again.
    bus.ch_addr  = {32'h500, 32'h400};
    bus.ch_rmask = 8'h21;
    tick();
    clear_inputs();
    tick();
    n_checks++;
    if (bus.mem_addr !== 32'h400 || bus.mem_rmask !== 4'h1)
      $display("FAIL rr_pair2_first got %h@%h want 1@400", bus.mem_rmask, bus.mem_addr);
    else n_pass++;
    bus.mem_resp = 1'b1;
    tick();
    clear_inputs();
    tick();
    tick();
    n_checks++;
    if (bus.mem_addr !== 32'h500 || bus.mem_rmask !== 4'h2)
      $display("FAIL rr_pair2_second got %h@%h want 2@500", bus.mem_rmask, bus.mem_addr);
    else n_pass++;
    bus.mem_resp = 1'b1;
    tick();
    clear_inputs();
    n_checks++;
    if (bus.ch_resp !== 2'b10) $display("FAIL rr_pair2_resp got %b want 10", bus.ch_resp);
    else n_pass++;
    tick();
  endtask

  task automatic test_conflict();
    do_reset();
    bus.ch_addr[63:32] = 32'h440;
    bus.ch_rmask[7:4]  = 4'h3;
    bus.ch_wmask[7:4]  = 4'h1;
    tick();
    clear_inputs();
    n_checks++;
    if (error !== 1'b1 || error_ch !== 2'd1)
      $display("FAIL conflict_error got %b/%0d want 1/1", error, error_ch);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.mem_rmask !== 4'h0 || bus.mem_wmask !== 4'h0 || error !== 1'b1)
        $display("FAIL conflict_hold got r=%h w=%h e=%b want 0/0/1",
                 bus.mem_rmask, bus.mem_wmask, error);
      else n_pass++;
    end
    do_reset();
    n_checks++;
    if (error !== 1'b0 || error_ch !== 2'd0)
      $display("FAIL conflict_clear got %b/%0d want 0/0", error, error_ch);
    else n_pass++;
  endtask

  task automatic test_duplicate();
    do_reset();
    bus.ch_addr[31:0] = 32'h600;
    bus.ch_rmask[3:0] = 4'hF;
    tick();
    clear_inputs();
    tick();
    n_checks++;
    if (bus.mem_rmask !== 4'hF || bus.mem_addr !== 32'h600)
      $display("FAIL dup_issue_a got %h@%h want f@600", bus.mem_rmask, bus.mem_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.mem_rmask !== 4'h0 || bus.mem_addr !== 32'h600)
      $display("FAIL dup_wait_a got %h@%h want 0@600", bus.mem_rmask, bus.mem_addr);
    else n_pass++;
    tick();
    tick();
    tick();
    tick();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h11223344;
    tick();
    clear_inputs();
    n_checks++;
    if (bus.ch_resp !== 2'b01 || bus.ch_rdata[31:0] !== 32'h11223344)
      $display("FAIL dup_resp_a got %b/%h want 01/11223344", bus.ch_resp, bus.ch_rdata[31:0]);
    else n_pass++;
    // Re-request in the owner's RESP cycle is legal.
    bus.ch_addr[31:0]  = 32'h900;
    bus.ch_wmask[3:0]  = 4'hF;
    bus.ch_wdata[31:0] = 32'hCAFEF00D;
    tick();
    clear_inputs();
    n_checks++;
    if (error !== 1'b0) $display("FAIL dup_resp_rereq_error got %b want 0", error);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.mem_addr !== 32'h900 || bus.mem_wmask !== 4'hF || bus.mem_wdata !== 32'hCAFEF00D)
      $display("FAIL dup_issue_b got %h@%h d=%h want f@900 d=cafef00d",
               bus.mem_wmask, bus.mem_addr, bus.mem_wdata);
    else n_pass++;
    tick();
    bus.ch_addr[31:0] = 32'hA00;
    bus.ch_rmask[3:0] = 4'hF;
    tick();
    clear_inputs();
    n_checks++;
    if (error !== 1'b1 || error_ch !== 2'd0)
      $display("FAIL dup_error got %b/%0d want 1/0", error, error_ch);
    else n_pass++;
    bus.mem_resp = 1'b1;
    tick();
    clear_inputs();
    n_checks++;
    if (bus.ch_resp !== 2'b01) $display("FAIL dup_resp_b got %b want 01", bus.ch_resp);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (bus.mem_rmask !== 4'h0 || bus.mem_addr !== 32'h900)
      $display("FAIL dup_dropped got %h@%h want 0@900", bus.mem_rmask, bus.mem_addr);
    else n_pass++;
  endtask

  task automatic test_spurious();
    do_reset();
    bus.mem_resp = 1'b1;
    tick();
    clear_inputs();
    n_checks++;
    if (error !== 1'b1 || error_ch !== 2'd2)
      $display("FAIL spurious_error got %b/%0d want 1/2", error, error_ch);
    else n_pass++;
    n_checks++;
    if (bus.ch_resp !== 2'b00) $display("FAIL spurious_resp got %b want 00", bus.ch_resp);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.ch_addr[63:32] = 32'hB00;
    bus.ch_rmask[7:4]  = 4'hF;
    tick();
    clear_inputs();
    tick();
    tick();
    n_checks++;
    if (bus.mem_addr !== 32'hB00) $display("FAIL mid_wait_addr got %h want b00", bus.mem_addr);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (bus.mem_addr !== 32'h0 || bus.mem_rmask !== 4'h0 || bus.ch_resp !== 2'b00 ||
        error !== 1'b0 || dut.pend_q !== 2'b00)
      $display("FAIL mid_reset got a=%h r=%h resp=%b e=%b pend=%b want all 0",
               bus.mem_addr, bus.mem_rmask, bus.ch_resp, error, dut.pend_q);
    else n_pass++;
    tick();
    tick();
    n_checks++;
    if (bus.mem_rmask !== 4'h0) $display("FAIL mid_no_reissue got %h want 0", bus.mem_rmask);
    else n_pass++;
    bus.mem_resp = 1'b1;
    tick();
    clear_inputs();
    n_checks++;
    if (error !== 1'b1 || error_ch !== 2'd2)
      $display("FAIL mid_stray_resp got %b/%0d want 1/2", error, error_ch);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_conflict();
    test_duplicate();
    test_spurious();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
